acp_arp_generator: RTL
======================

Name: acp_arp_generator

Overview:
Parametrised successor to the fixed-ratio ACP divider: generates radar azimuth change pulses (RADAR_ACP) with a runtime-loadable period and fixed pulse width, plus the once-per-revolution azimuth reference pulse (RADAR_ARP). Maintains an azimuth index and revolution count, with start/stop control. Sits between the 100 MHz fabric clock and the radar simulator's target/sweep logic, which consumes AZIMUTH and ARP for sweep alignment.

Parameters:
DIV_W, 32, width of the period value in IN_CLK cycles
DIV_DEFAULT, 585938, ACP period after reset (about 170.7 Hz at 100 MHz)
ACP_PER_REV, 4096, ACP pulses per antenna revolution; any value of 2 or more
AZ_W, 12, AZIMUTH width; must satisfy 2^AZ_W >= ACP_PER_REV
PULSE_CYCLES, 100, ACP/ARP high time in IN_CLK cycles; 1 or more
REV_W, 16, revolution counter width

Ports:
IN_CLK  in  1  fabric clock, 100 MHz
RST  in  1  asynchronous active-high reset
EN  in  1  run enable, level
DIV_LOAD  in  1  single-cycle strobe; captures DIV_VALUE into shadow
DIV_VALUE  in  DIV_W  requested ACP period in cycles
RADAR_ACP  out  1  azimuth change pulse, registered
RADAR_ARP  out  1  azimuth reference pulse, registered, coincident with the ACP of azimuth 0
AZIMUTH  out  AZ_W  index of the most recent ACP, 0..ACP_PER_REV-1
REV_COUNT  out  REV_W  completed revolutions, wraps modulo 2^REV_W
RUNNING  out  1  high in RUN and DRAIN

Behaviour:
- Reset (async assert, sync release): RADAR_ACP=0, RADAR_ARP=0, AZIMUTH=ACP_PER_REV-1 (so the first pulse is azimuth 0 with ARP), REV_COUNT=0, RUNNING=0, state=IDLE, shadow=active=DIV_DEFAULT, period counter=0, pulse counter=0.
- Period clamp: on capture, any DIV_VALUE below PULSE_CYCLES+1 (including 0) is stored as PULSE_CYCLES+1. Every period therefore has at least one low cycle.
- DIV_LOAD writes the shadow in any state. Shadow is copied to active at each period boundary and on the IDLE→RUN transition.
- If DIV_LOAD and a boundary occur in the same cycle, the newly presented value reaches active at that boundary.
- Period counter runs 0..active-1 in RUN. The boundary is the cycle with counter==active-1; the counter wraps to 0 there.
- At a boundary:
  - AZIMUTH increments; ACP_PER_REV-1 wraps to 0.
  - If the new AZIMUTH is 0: RADAR_ARP asserts together with RADAR_ACP, and REV_COUNT increments. The first revolution after reset does not increment REV_COUNT (first-pulse flag).
  - RADAR_ACP (and ARP if applicable) go high on the next cycle and stay high exactly PULSE_CYCLES cycles.
- Latency: EN sampled high in IDLE → RUNNING=1 next cycle → first RADAR_ACP rise exactly active cycles after the EN-sample edge.
- FSM:
  - IDLE: EN=1 → RUN.
  - RUN: EN=0 with no pulse high → IDLE; EN=0 with pulse high → DRAIN.
  - DRAIN: pulse completes its full width → IDLE. No new boundaries; EN re-asserting does not abort the drain.
- In IDLE, AZIMUTH and REV_COUNT hold. The next start continues from the held azimuth, not from 0.
- Reset mid-pulse drops the outputs immediately (asynchronous).

Optional Feature:
Macro ACP_AZ_PRESET_EN.
- Defined: adds ports AZ_PRESET_LOAD (in, 1) and AZ_PRESET (in, AZ_W). A strobe in IDLE sets AZIMUTH=AZ_PRESET-1 mod ACP_PER_REV, so the next pulse reports AZ_PRESET. A strobe in RUN or DRAIN is ignored. Out-of-range preset values are reduced modulo ACP_PER_REV.
- Undefined: ports absent; azimuth changes only via reset and pulses.

Decomposition:
- Package acp_pkg: FSM state enum (IDLE, RUN, DRAIN), default constants (DIV_DEFAULT, PULSE_CYCLES), and the period clamp function.
- Sub-module acp_period_counter: active/shadow period registers, clamp, counter and boundary strobe. The top level holds the FSM, pulse stretcher, azimuth and revolution logic.

Test Plan:
(Bench parameters: DIV_DEFAULT=10, ACP_PER_REV=4, PULSE_CYCLES=2.)
- Reset, then EN=1 at cycle 0 → ACP rises at cycle 10 with ARP=1 and AZIMUTH=0, high 2 cycles. Next ACP at cycle 20 (AZIMUTH=1); ARP again at cycle 50 with REV_COUNT=1.
- DIV_LOAD with 6 mid-period → current period stays 10; following periods are 6 cycles. DIV_LOAD with 0 → period clamped to 3 (2 high, 1 low).
- DIV_LOAD in the same cycle as a boundary, value 7 → the very next period is 7 cycles.
- EN drops on the first high cycle of ACP → pulse still lasts 2 cycles, RUNNING falls after it, AZIMUTH held. Re-enable → next pulse 10 cycles later with AZIMUTH+1.
- RST asserted during an ACP high → ACP, ARP and RUNNING go 0 immediately; AZIMUTH=3; REV_COUNT=0.
- With ACP_AZ_PRESET_EN: preset 2 in IDLE, then EN → first pulse AZIMUTH=2, no ARP; preset strobe during RUN has no effect.

Source files
------------

// File: rtl/acp_pkg.sv
// Shared FSM state type, default constants and period clamp for the ACP/ARP generator.
package acp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } acp_state_e;

    localparam int unsigned ACP_DIV_DEFAULT  = 32'd585938;
    localparam int unsigned ACP_PULSE_CYCLES = 32'd100;
    localparam int unsigned CLAMP_W          = 32'd64;

    // Raise any period too short to leave at least one low cycle after the pulse.
    function automatic logic [CLAMP_W-1:0] clamp_period(
        input logic [CLAMP_W-1:0] value,
        input logic [CLAMP_W-1:0] min_value
    );
        if (value < min_value) begin
            return min_value;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/acp_period_counter.sv
// Shadow/active ACP period registers and the period counter that flags each boundary cycle.
module acp_period_counter
    import acp_pkg::*;
#(
    parameter int unsigned DIV_W        = 32,
    parameter int unsigned DIV_DEFAULT  = ACP_DIV_DEFAULT,
    parameter int unsigned PULSE_CYCLES = ACP_PULSE_CYCLES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             run_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] value_i,
    output logic             boundary_o
);

    localparam logic [CLAMP_W-1:0] MIN_PERIOD   = CLAMP_W'(PULSE_CYCLES) + 64'd1;
    localparam logic [DIV_W-1:0]   RESET_PERIOD = DIV_W'(DIV_DEFAULT);

    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] count_q, count_d;
    logic             boundary_s;

    assign boundary_s = run_i && (count_q == (active_q - DIV_W'(1'b1)));
    assign boundary_o = boundary_s;

    // A load in the boundary cycle is forwarded straight into the next active period.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        count_d  = count_q;
        if (load_i) begin
            shadow_d = DIV_W'(clamp_period(CLAMP_W'(value_i), MIN_PERIOD));
        end else begin
            shadow_d = shadow_q;
        end
        if (start_i || boundary_s) begin
            active_d = shadow_d;
            count_d  = {DIV_W{1'b0}};
        end else if (run_i) begin
            active_d = active_q;
            count_d  = count_q + DIV_W'(1'b1);
        end else begin
            active_d = active_q;
            count_d  = count_q;
        end
    end

    // Period state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q <= RESET_PERIOD;
            active_q <= RESET_PERIOD;
            count_q  <= {DIV_W{1'b0}};
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/acp_arp_generator.sv
// Radar ACP/ARP generator: run/drain FSM, pulse stretcher, azimuth index and revolution count.
// Optional azimuth preset ports are enabled by defining ACP_AZ_PRESET_EN.
module acp_arp_generator
    import acp_pkg::*;
#(
    parameter int unsigned DIV_W        = 32,
    parameter int unsigned DIV_DEFAULT  = ACP_DIV_DEFAULT,
    parameter int unsigned ACP_PER_REV  = 4096,
    parameter int unsigned AZ_W         = 12,
    parameter int unsigned PULSE_CYCLES = ACP_PULSE_CYCLES,
    parameter int unsigned REV_W        = 16
) (
    input  logic             IN_CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             DIV_LOAD,
    input  logic [DIV_W-1:0] DIV_VALUE,
`ifdef ACP_AZ_PRESET_EN
    input  logic             AZ_PRESET_LOAD,
    input  logic [AZ_W-1:0]  AZ_PRESET,
`endif
    output logic             RADAR_ACP,
    output logic             RADAR_ARP,
    output logic [AZ_W-1:0]  AZIMUTH,
    output logic [REV_W-1:0] REV_COUNT,
    output logic             RUNNING
);

    localparam int unsigned     PCNT_W    = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_CYCLES - 1);
    localparam logic [AZ_W-1:0]   AZ_LAST   = AZ_W'(ACP_PER_REV - 1);
    localparam logic [AZ_W-1:0]   AZ_ZERO   = {AZ_W{1'b0}};

    acp_state_e        state_q, state_d;
    logic              acp_q, acp_d;
    logic              arp_q, arp_d;
    logic              running_q, running_d;
    logic              first_q, first_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [AZ_W-1:0]   az_q, az_d, az_inc_s;
    logic [REV_W-1:0]  rev_q, rev_d;
    logic              start_s, run_s, boundary_s;

    assign start_s  = (state_q == IDLE) && EN;
    assign run_s    = (state_q == RUN);
    assign az_inc_s = (az_q == AZ_LAST) ? AZ_ZERO : (az_q + AZ_W'(1'b1));

`ifdef ACP_AZ_PRESET_EN
    logic            preset_s;
    logic [AZ_W-1:0] preset_mod_s, preset_prev_s;
    assign preset_s      = (state_q == IDLE) && AZ_PRESET_LOAD;
    assign preset_mod_s  = AZ_W'(32'(AZ_PRESET) % ACP_PER_REV);
    assign preset_prev_s = (preset_mod_s == AZ_ZERO) ? AZ_LAST : (preset_mod_s - AZ_W'(1'b1));
`endif

    acp_period_counter #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT),
        .PULSE_CYCLES(PULSE_CYCLES)
    ) u_period (
        .clk_i     (IN_CLK),
        .rst_i     (RST),
        .start_i   (start_s),
        .run_i     (run_s),
        .load_i    (DIV_LOAD),
        .value_i   (DIV_VALUE),
        .boundary_o(boundary_s)
    );

    // Next-state logic for pulse stretcher, azimuth/revolution tracking and run FSM.
    always_comb begin
        acp_d   = acp_q;
        arp_d   = arp_q;
        pcnt_d  = pcnt_q;
        az_d    = az_q;
        rev_d   = rev_q;
        first_d = first_q;
        state_d = state_q;

        if (boundary_s) begin
            acp_d  = 1'b1;
            arp_d  = (az_inc_s == AZ_ZERO);
            pcnt_d = {PCNT_W{1'b0}};
        end else if (acp_q && (pcnt_q == PCNT_LAST)) begin
            acp_d  = 1'b0;
            arp_d  = 1'b0;
            pcnt_d = {PCNT_W{1'b0}};
        end else if (acp_q) begin
            acp_d  = 1'b1;
            arp_d  = arp_q;
            pcnt_d = pcnt_q + PCNT_W'(1'b1);
        end else begin
            acp_d  = 1'b0;
            arp_d  = 1'b0;
            pcnt_d = pcnt_q;
        end

        // The first azimuth-0 pulse after reset opens revolution 0 rather than completing one.
        if (boundary_s) begin
            az_d = az_inc_s;
            if ((az_inc_s == AZ_ZERO) && first_q) begin
                first_d = 1'b0;
                rev_d   = rev_q;
            end else if (az_inc_s == AZ_ZERO) begin
                first_d = first_q;
                rev_d   = rev_q + REV_W'(1'b1);
            end else begin
                first_d = first_q;
                rev_d   = rev_q;
            end
        end
`ifdef ACP_AZ_PRESET_EN
        else if (preset_s) begin
            az_d = preset_prev_s;
        end
`endif
        else begin
            az_d = az_q;
        end

        case (state_q)
            IDLE: begin
                if (EN) state_d = RUN;
                else    state_d = IDLE;
            end
            RUN: begin
                if (EN)         state_d = RUN;
                else if (acp_d) state_d = DRAIN;
                else            state_d = IDLE;
            end
            DRAIN: begin
                if (acp_d) state_d = DRAIN;
                else       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        running_d = (state_d != IDLE);
    end

    // FSM and registered outputs.
    always_ff @(posedge IN_CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            acp_q     <= 1'b0;
            arp_q     <= 1'b0;
            pcnt_q    <= {PCNT_W{1'b0}};
            az_q      <= AZ_LAST;
            rev_q     <= {REV_W{1'b0}};
            first_q   <= 1'b1;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acp_q     <= acp_d;
            arp_q     <= arp_d;
            pcnt_q    <= pcnt_d;
            az_q      <= az_d;
            rev_q     <= rev_d;
            first_q   <= first_d;
            running_q <= running_d;
        end
    end

    assign RADAR_ACP = acp_q;
    assign RADAR_ARP = arp_q;
    assign AZIMUTH   = az_q;
    assign REV_COUNT = rev_q;
    assign RUNNING   = running_q;

endmodule
